pam4_isi_channel: RTL
=====================

Name: pam4_isi_channel

Overview:
- Synthetic channel model placed between pam_4_encode and pam_4_decode in the Tx/Rx simulation chain.
- Each valid PAM-4 voltage sample passes through a 4-tap FIR inter-symbol-interference filter. Taps are programmable.
- Optional LFSR-based bounded noise is added, then the result is saturated and forwarded with a valid strobe.
- With default taps and noise off, the block is transparent apart from a fixed 2-cycle latency, so the existing decode and BER path is unchanged.

Parameters:
- SIGNAL_RESOLUTION, 8, width of the signed two's-complement voltage samples in and out.
- NUM_TAPS, 4, FIR length. Tap 0 is the main cursor; taps 1..3 are post-cursors.
- COEF_WIDTH, 8, signed tap coefficient width in Q1.(COEF_WIDTH-2) format. 64 represents 1.0 for width 8.
- NOISE_BITS, 3, width of the signed noise term added per sample. Legal range is 1..8.
- LFSR_SEED, 16'hACE1, reset value of the noise LFSR. Must be non-zero.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- voltage_level_in  in  SIGNAL_RESOLUTION  signed input sample.
- voltage_level_in_valid  in  1  input sample qualifier.
- tap_wr_en  in  1  coefficient write strobe.
- tap_wr_addr  in  2  tap index, 0..NUM_TAPS-1.
- tap_wr_data  in  COEF_WIDTH  signed coefficient.
- noise_en  in  1  1 = add LFSR noise; 0 = noise term forced to 0.
- voltage_level_out  out  SIGNAL_RESOLUTION  signed channel output.
- voltage_level_out_valid  out  1  output qualifier.

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high.
  - While rst=1 at a rising edge: delay line x[0..3] cleared to 0, pipeline registers cleared, voltage_level_out=0, voltage_level_out_valid=0.
  - Also on reset: taps reloaded to tap0=64 and tap1..3=0 (identity), LFSR loaded with LFSR_SEED.
  - Reset asserted mid-stream discards all in-flight samples; no valid output appears for them.
- Delay line:
  - Shifts only on cycles where voltage_level_in_valid=1: x[0]<=in, x[k]<=x[k-1].
  - Invalid cycles (bubbles) hold all state, including the LFSR.
- Stage 1:
  - Registered on valid-in.
  - Computes the products p[k] = tap[k] * x_next[k], each a 16-bit signed value.
  - x_next is the delay line including the sample being accepted, so the new sample multiplies tap0 in the same stage.
- Stage 2:
  - Sum of the 4 products, 18-bit signed.
  - Round: add 2^(COEF_WIDTH-3) = 32, then arithmetic shift right by COEF_WIDTH-2 = 6.
  - Add the noise term n.
  - Saturate to [-2^(SIGNAL_RESOLUTION-1), 2^(SIGNAL_RESOLUTION-1)-1] = [-128, 127].
  - Register the result to voltage_level_out.
- Latency and valid:
  - voltage_level_out_valid is voltage_level_in_valid delayed by exactly 2 cycles. One output is produced per input and none is dropped.
  - Output data holds its last value while valid=0.
- Noise:
  - 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1. Advances once per accepted sample, regardless of noise_en.
  - n = sign-extended LFSR[NOISE_BITS-1:0], giving range -4..3 for the default width. n=0 when noise_en=0.
  - noise_en is sampled on the same edge as the sample it applies to.
- Tap writes:
  - A tap_wr_en write updates tap[tap_wr_addr] at the rising edge.
  - A sample accepted on the same edge uses the old coefficient; the new value applies from the next accepted sample.
  - Writes are accepted while rst=0 regardless of valid activity.
  - tap_wr_addr is always in range for NUM_TAPS=4.
- Saturation:
  - Out-of-range positive sums clamp to 127; out-of-range negative sums clamp to -128.
  - There is no wrap-around anywhere. Intermediate widths are sized so the 18-bit sum cannot overflow: worst case is 4 × 128 × 128 = 65536, well inside ±2^17.

Test Plan:
- Identity: reset released, noise_en=0, stream levels -84, -28, 28, 84 with valid=1 → outputs equal the inputs 2 cycles later; downstream pam_4_decode / grey_decode / prbs31_checker report 0 bit errors.
- Impulse response: taps {64, 32, -16, 8}, input 84 then 0, 0, 0, 0 → outputs 84, 42, -21, 11, 0.
  - Derivation: 84×32/64 = 42; -16×84 = -1344, +32 → -1312 >>>6 = -21; 8×84 = 672, +32 → 704 >>>6 = 11.
- Saturation: taps {127, 127, 127, 127}, four consecutive inputs of 84 → the output after the 4th sample is 127; four inputs of -84 → -128.
- Bubbles: taps {64, 32, 0, 0}, input 56, valid low 3 cycles, then 0 → outputs 56 then 28. valid_out mirrors the input gaps with 2-cycle delay.
- Tap write collision: tap1 written 0→64 on the same edge as a sample is accepted → that sample is filtered with the old tap; the following sample uses 64.
- Noise and reset: noise_en=1, identity taps, 1000 samples of 28 → every output lies in 24..31 and is not constant. rst pulsed mid-stream → valid_out=0 and output=0 the next cycle, with no stale output after release.

Source files
------------

// File: rtl/pam4_isi_channel.sv
// Synthetic PAM-4 channel: 4-tap programmable ISI FIR, optional bounded LFSR noise,
// saturation, and a fixed 2-cycle valid-qualified pipeline.
module pam4_isi_channel #(
  parameter int          SIGNAL_RESOLUTION = 8,
  parameter int          NUM_TAPS          = 4,
  parameter int          COEF_WIDTH        = 8,
  parameter int          NOISE_BITS        = 3,
  parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SIGNAL_RESOLUTION-1:0] voltage_level_in,
  input  logic                         voltage_level_in_valid,
  input  logic                         tap_wr_en,
  input  logic [1:0]                   tap_wr_addr,
  input  logic [COEF_WIDTH-1:0]        tap_wr_data,
  input  logic                         noise_en,
  output logic [SIGNAL_RESOLUTION-1:0] voltage_level_out,
  output logic                         voltage_level_out_valid
);

  localparam int PW    = SIGNAL_RESOLUTION + COEF_WIDTH;
  localparam int SW    = PW + $clog2(NUM_TAPS);
  localparam int FRAC  = COEF_WIDTH - 2;
  localparam int ROUND = 1 << (FRAC - 1);
  localparam logic signed [SW-1:0] MAXV = SW'((1 << (SIGNAL_RESOLUTION - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = SW'(-(1 << (SIGNAL_RESOLUTION - 1)));

  logic signed [SIGNAL_RESOLUTION-1:0] x      [NUM_TAPS];
  logic signed [SIGNAL_RESOLUTION-1:0] x_next [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0]        tap    [NUM_TAPS];
  logic signed [PW-1:0]                prod   [NUM_TAPS];
  logic signed [NOISE_BITS-1:0]        noise_q;
  logic [15:0]                         lfsr;
  logic                                v1;

  logic signed [SW-1:0]                sum;
  logic signed [SW-1:0]                rnd;
  logic signed [SW-1:0]                noisy;
  logic signed [SIGNAL_RESOLUTION-1:0] sat;

  // The accepted sample enters tap 0 in the same stage it is captured.
  always_comb begin
    x_next[0] = voltage_level_in;
    for (int unsigned k = 1; k < NUM_TAPS; k++) x_next[k] = x[k-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        x[k]    <= '0;
        prod[k] <= '0;
        tap[k]  <= (k == 0) ? COEF_WIDTH'(1 << FRAC) : '0;
      end
      noise_q <= '0;
      lfsr    <= LFSR_SEED;
      v1      <= 1'b0;
    end else begin
      v1 <= voltage_level_in_valid;
      if (voltage_level_in_valid) begin
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
          x[k]    <= x_next[k];
          prod[k] <= PW'(tap[k]) * PW'(x_next[k]);
        end
        noise_q <= noise_en ? lfsr[NOISE_BITS-1:0] : '0;
        lfsr    <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      end
      // Non-blocking write: a sample accepted on this edge still sees the old tap.
      if (tap_wr_en) tap[tap_wr_addr] <= tap_wr_data;
    end
  end

  always_comb begin
    sum = '0;
    for (int unsigned k = 0; k < NUM_TAPS; k++) sum = sum + SW'(prod[k]);
    rnd   = (sum + SW'(ROUND)) >>> FRAC;
    noisy = rnd + SW'(noise_q);
    if (noisy > MAXV)      sat = MAXV[SIGNAL_RESOLUTION-1:0];
    else if (noisy < MINV) sat = MINV[SIGNAL_RESOLUTION-1:0];
    else                   sat = noisy[SIGNAL_RESOLUTION-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      voltage_level_out       <= '0;
      voltage_level_out_valid <= 1'b0;
    end else begin
      voltage_level_out_valid <= v1;
      if (v1) voltage_level_out <= sat;
    end
  end

endmodule
